// File: rtl/img_sensor_tx.sv
// img_sensor_tx: parallel pixel-bus transmitter driving img_fv/img_lv/img_d from a ready/trigger source.
// Define IMG_SENSOR_TX_PATTERN_EN to add cmd_pattern and an internal incrementing test pattern.
module img_sensor_tx #(
    parameter int ImageWidth    = 256,
    parameter int ImageHeight   = 256,
    parameter int FvLeadCycles  = 4,
    parameter int HBlankCycles  = 8,
    parameter int FvTrailCycles = 4,
    parameter int VBlankCycles  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_trigger,
    input  logic [7:0]  cmd_frameCount,
    input  logic        cmd_stop,
`ifdef IMG_SENSOR_TX_PATTERN_EN
    input  logic        cmd_pattern,
`endif
    input  logic        px_ready,
    output logic        px_trigger,
    input  logic [15:0] px_data,
    output logic        img_fv,
    output logic        img_lv,
    output logic [11:0] img_d,
    output logic        status_busy,
    output logic        status_frameDone,
    output logic [15:0] status_underrunCount
);

    // state     | meaning
    // ST_IDLE   | waiting for cmd_trigger, fv low
    // ST_LEAD   | fv high ahead of the first line
    // ST_LINE   | fv and lv high, one pixel per cycle
    // ST_HBLANK | fv high, lv low between lines
    // ST_TRAIL  | fv high after the last line
    // ST_VBLANK | fv low between frames
    typedef enum logic [2:0] {
        ST_IDLE, ST_LEAD, ST_LINE, ST_HBLANK, ST_TRAIL, ST_VBLANK
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MaxCycles = max2(max2(max2(ImageWidth, FvLeadCycles), max2(HBlankCycles, FvTrailCycles)),
                                    VBlankCycles);
    localparam int TW = $clog2(MaxCycles + 1);
    localparam int YW = $clog2(ImageHeight + 1);
    localparam logic [TW-1:0] LeadLd  = TW'(FvLeadCycles - 1);
    localparam logic [TW-1:0] LineLd  = TW'(ImageWidth - 1);
    localparam logic [TW-1:0] HBlkLd  = TW'(HBlankCycles - 1);
    localparam logic [TW-1:0] TrailLd = TW'(FvTrailCycles - 1);
    localparam logic [TW-1:0] VBlkLd  = TW'(VBlankCycles - 1);
    localparam logic [YW-1:0] YLast   = YW'(ImageHeight - 1);

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [YW-1:0] r_y;
    logic [7:0]    r_frames_left;
    logic          r_continuous, r_stop_req;
    logic          r_fv, r_lv, r_frame_done;
    logic [11:0]   r_d;
    logic [15:0]   r_underrun;
    logic          w_fv, w_lv, w_start, w_restart, w_y_inc, w_frame_end;
    logic          w_tc, w_stop, w_underrun, w_pattern;
    logic [11:0]   w_pix;
    logic          w_unused_px;

    assign w_unused_px = ^px_data[15:12];

`ifdef IMG_SENSOR_TX_PATTERN_EN
    logic        r_pattern;
    logic [11:0] r_pat;

    assign w_pattern = r_pattern;
    assign w_pix     = r_pattern ? r_pat : (px_ready ? px_data[11:0] : 12'd0);

    // r_pat counts pixels since frame start, which equals (x + y*ImageWidth) mod 4096
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= 1'b0;
            r_pat     <= 12'd0;
        end else begin
            if (w_start)
                r_pattern <= cmd_pattern;
            if (w_start || w_restart)
                r_pat <= 12'd0;
            else if (w_lv)
                r_pat <= r_pat + 12'd1;
        end
    end
`else
    assign w_pattern = 1'b0;
    assign w_pix     = px_ready ? px_data[11:0] : 12'd0;
`endif

    assign w_tc       = (r_timer == '0);
    assign w_stop     = r_stop_req | cmd_stop;
    assign w_underrun = w_lv & ~px_ready & ~w_pattern;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = w_tc ? r_timer : r_timer - 1'b1;
        w_fv        = 1'b0;
        w_lv        = 1'b0;
        w_start     = 1'b0;
        w_restart   = 1'b0;
        w_y_inc     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_trigger) begin
                    w_state_nxt = ST_LEAD;
                    w_timer_nxt = LeadLd;
                    w_start     = 1'b1;
                end
            end
            ST_LEAD: begin
                w_fv = 1'b1;
                if (w_tc) begin
                    w_state_nxt = ST_LINE;
                    w_timer_nxt = LineLd;
                end
            end
            ST_LINE: begin
                w_fv = 1'b1;
                w_lv = 1'b1;
                if (w_tc) begin
                    if (r_y == YLast) begin
                        w_state_nxt = ST_TRAIL;
                        w_timer_nxt = TrailLd;
                    end else begin
                        w_state_nxt = ST_HBLANK;
                        w_timer_nxt = HBlkLd;
                    end
                end
            end
            ST_HBLANK: begin
                w_fv = 1'b1;
                if (w_tc) begin
                    w_state_nxt = ST_LINE;
                    w_timer_nxt = LineLd;
                    w_y_inc     = 1'b1;
                end
            end
            ST_TRAIL: begin
                w_fv = 1'b1;
                if (w_tc) begin
                    w_state_nxt = ST_VBLANK;
                    w_timer_nxt = VBlkLd;
                    w_frame_end = 1'b1;
                end
            end
            ST_VBLANK: begin
                // a stop arriving on the very last blanking cycle still ends the sequence here
                if (w_tc) begin
                    if (w_stop || (!r_continuous && r_frames_left == 8'd0)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LEAD;
                        w_timer_nxt = LeadLd;
                        w_restart   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_y           <= '0;
            r_frames_left <= 8'd0;
            r_continuous  <= 1'b0;
            r_stop_req    <= 1'b0;
            r_fv          <= 1'b0;
            r_lv          <= 1'b0;
            r_d           <= 12'd0;
            r_frame_done  <= 1'b0;
            r_underrun    <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_fv    <= w_fv;
            r_lv    <= w_lv;
            r_d     <= w_lv ? w_pix : 12'd0;
            if (r_fv && !w_fv)
                r_frame_done <= ~r_frame_done;
            if (w_start || w_restart)
                r_y <= '0;
            else if (w_y_inc)
                r_y <= r_y + 1'b1;
            if (w_start) begin
                r_frames_left <= cmd_frameCount;
                r_continuous  <= (cmd_frameCount == 8'd0);
                r_underrun    <= 16'd0;
                r_stop_req    <= 1'b0;
            end else begin
                if (cmd_stop && r_state != ST_IDLE)
                    r_stop_req <= 1'b1;
                if (w_underrun && r_underrun != 16'hFFFF)
                    r_underrun <= r_underrun + 16'd1;
                if (w_frame_end && !r_continuous && r_frames_left != 8'd0)
                    r_frames_left <= r_frames_left - 8'd1;
            end
        end
    end

    assign px_trigger           = w_lv & ~w_pattern;
    assign img_fv               = r_fv;
    assign img_lv               = r_lv;
    assign img_d                = r_d;
    assign status_busy          = (r_state != ST_IDLE);
    assign status_frameDone     = r_frame_done;
    assign status_underrunCount = r_underrun;

endmodule

// File: tb/tb_img_sensor_tx.sv
// tb_img_sensor_tx: randomized bench for img_sensor_tx against an arithmetic frame-timeline model.
module tb_img_sensor_tx;
    localparam int W     = 4;
    localparam int H     = 3;
    localparam int LEAD  = 2;
    localparam int HB    = 3;
    localparam int TRAIL = 2;
    localparam int VB    = 5;
    localparam int FL    = LEAD + H * W + (H - 1) * HB + TRAIL;
    localparam int P     = FL + VB;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_trigger;
    logic [7:0]  cmd_frameCount;
    logic        cmd_stop;
    logic        px_ready;
    logic        px_trigger;
    logic [15:0] px_data;
    logic        img_fv, img_lv;
    logic [11:0] img_d;
    logic        status_busy, status_frameDone;
    logic [15:0] status_underrunCount;
`ifdef IMG_SENSOR_TX_PATTERN_EN
    logic        cmd_pattern = 1'b0;
`endif

    always #5 clk = ~clk;

    img_sensor_tx #(
        .ImageWidth(W), .ImageHeight(H), .FvLeadCycles(LEAD),
        .HBlankCycles(HB), .FvTrailCycles(TRAIL), .VBlankCycles(VB)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_trigger(cmd_trigger), .cmd_frameCount(cmd_frameCount), .cmd_stop(cmd_stop),
`ifdef IMG_SENSOR_TX_PATTERN_EN
        .cmd_pattern(cmd_pattern),
`endif
        .px_ready(px_ready), .px_trigger(px_trigger), .px_data(px_data),
        .img_fv(img_fv), .img_lv(img_lv), .img_d(img_d),
        .status_busy(status_busy), .status_frameDone(status_frameDone),
        .status_underrunCount(status_underrunCount)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit exp_done;
    int exp_under;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // k counts cycles from the first img_fv-high sample of the sequence; nf frames in total
    function automatic bit m_fv(input int k, input int nf);
        return ((k / P) < nf) && ((k % P) < FL);
    endfunction

    function automatic bit m_lv(input int k, input int nf, output int pix);
        int u;
        pix = 0;
        if ((k / P) >= nf) return 1'b0;
        u = (k % P) - LEAD;
        if (u < 0) return 1'b0;
        if ((u / (W + HB)) >= H || (u % (W + HB)) >= W) return 1'b0;
        pix = (u / (W + HB)) * W + (u % (W + HB));
        return 1'b1;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, ".fv"}, img_fv, 1'b0);
        chk({tag, ".lv"}, img_lv, 1'b0);
        chk({tag, ".d"}, img_d, 12'd0);
        chk({tag, ".busy"}, status_busy, 1'b0);
        chk({tag, ".done"}, status_frameDone, exp_done);
        chk({tag, ".under"}, status_underrunCount, exp_under);
    endtask

    task automatic idle(input int n, input bit poke_stop);
        for (int i = 0; i < n; i++) begin
            cmd_stop = poke_stop & 1'($urandom);
            px_ready = 1'($urandom);
            px_data  = 16'($urandom);
            chk("idle.px_trigger", px_trigger, 1'b0);
            @(posedge clk); #1;
            check_quiet("idle");
        end
        cmd_stop = 1'b0;
        px_ready = 1'b0;
    endtask

    // ready_mode: 0 always ready, 1 random, 2 low only for pixel index 5 of each frame
    task automatic run_seq(input int fc, input int ready_mode, input int stop_at, input bit spam,
                           input int abort_at, input bit stop_with_trig);
        int nf, s, src, pops_exp, pops_dut, pix;
        bit lv, fv, fvp, rdy, aborted;
        logic [15:0] data;
        logic [11:0] exp_d;
        nf = (fc == 0) ? 1000 : fc;
        cmd_trigger    = 1'b1;
        cmd_frameCount = 8'(fc);
        cmd_stop       = stop_with_trig;
        @(posedge clk); #1;
        cmd_trigger = 1'b0;
        cmd_stop    = 1'b0;
        exp_under = 0; src = 0; pops_exp = 0; pops_dut = 0; fvp = 1'b0; aborted = 1'b0;
        s = 0;
        while (s < nf * P + 3 && s < 4000) begin
            if (s == stop_at) begin
                cmd_stop = 1'b1;
                if (s < nf * P && (s / P + 1) < nf) nf = s / P + 1;
            end else begin
                cmd_stop = 1'b0;
            end
            if (spam && s < nf * P) begin
                cmd_trigger    = 1'($urandom);
                cmd_frameCount = 8'($urandom);
            end else begin
                cmd_trigger = 1'b0;
            end
            lv = m_lv(s, nf, pix);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 99) < 75);
                default: rdy = !(lv && pix == 5);
            endcase
            data     = rdy ? {4'($urandom), 12'(src)} : 16'($urandom);
            px_ready = rdy;
            px_data  = data;
            chk($sformatf("px_trigger@%0d", s), px_trigger, lv);
            if (px_trigger && px_ready) pops_dut++;
            if (lv && rdy) begin
                exp_d = data[11:0];
                pops_exp++;
                src++;
            end else begin
                exp_d = 12'd0;
            end
            if (lv && !rdy) exp_under++;
            @(posedge clk); #1;
            fv = m_fv(s, nf);
            if (fvp && !fv) exp_done = ~exp_done;
            fvp = fv;
            chk($sformatf("fv@%0d", s), img_fv, fv);
            chk($sformatf("lv@%0d", s), img_lv, lv);
            chk($sformatf("d@%0d", s), img_d, exp_d);
            chk($sformatf("busy@%0d", s), status_busy, (s + 1) < nf * P);
            chk($sformatf("done@%0d", s), status_frameDone, exp_done);
            chk($sformatf("under@%0d", s), status_underrunCount, exp_under);
            if (s == abort_at) begin
                #2 rst = 1'b1;
                exp_done  = 1'b0;
                exp_under = 0;
                #1 check_quiet("rst_midline");
                #1 rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            s++;
        end
        if (!aborted && s >= 4000) chk("seq_bound", 1'b1, 1'b0);
        cmd_trigger    = 1'b0;
        cmd_stop       = 1'b0;
        cmd_frameCount = 8'd0;
        px_ready       = 1'b0;
        if (!aborted) chk("pops", pops_dut, pops_exp);
    endtask

    initial begin
        rst = 1'b1;
        cmd_trigger = 1'b0; cmd_frameCount = 8'd0; cmd_stop = 1'b0;
        px_ready = 1'b0; px_data = 16'd0;
        exp_done = 1'b0; exp_under = 0;
        #23;
        check_quiet("reset");
        #4 rst = 1'b0;
        @(posedge clk); #1;
        idle(3, 1'b1);

        run_seq(1, 0, -1, 1'b0, -1, 1'b0);
        chk("frame1.under_total", status_underrunCount, 16'd0);
        idle(2, 1'b0);

        run_seq(1, 2, -1, 1'b0, -1, 1'b0);
        chk("frame2.under_total", status_underrunCount, 16'd1);
        idle(2, 1'b1);

        run_seq(0, 1, P + int'($urandom_range(0, P - 1)), 1'b0, -1, 1'b0);
        idle(2, 1'b0);

        run_seq(3, 0, -1, 1'b0, LEAD + W + HB + 1, 1'b0);
        run_seq(1, 0, -1, 1'b0, -1, 1'b0);
        idle(1, 1'b0);

        run_seq(3, 1, -1, 1'b1, -1, 1'b0);
        idle(2, 1'b1);

        run_seq(2, 1, -1, 1'b0, -1, 1'b1);
        idle(2, 1'b0);

        for (int i = 0; i < 4; i++) begin
            run_seq(int'($urandom_range(1, 2)), 1,
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 2 * P)) : -1,
                    1'($urandom), -1, 1'($urandom));
            idle(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/img_sensor_tx.md
Name: img_sensor_tx

Overview:
- Parallel pixel-bus transmitter: the sensor-side end of the img_dclk/img_fv/img_lv/img_d interface that the capture controller receives.
- Streams 12-bit pixels from a ready/trigger source (normally an AFIFO read port) as frames with programmable line/frame blanking.
- Used as an on-FPGA sensor emulator for loopback capture tests, and to replay RAM images onto the pixel bus.

Parameters:
- ImageWidth, 256, pixels per line (img_lv-high cycles per line); >=1
- ImageHeight, 256, lines per frame; >=1
- FvLeadCycles, 4, cycles img_fv high before first img_lv of a frame; >=1
- HBlankCycles, 8, img_lv-low cycles between consecutive lines; >=1
- FvTrailCycles, 4, cycles img_fv high after last line ends; >=1
- VBlankCycles, 16, img_fv-low cycles after each frame; >=1

Ports:
- clk  in  1  pixel clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- cmd_trigger  in  1  pulse; start a frame sequence (ignored unless Idle)
- cmd_frameCount  in  8  frames to send, sampled on cmd_trigger; 0 = continuous
- cmd_stop  in  1  pulse; end sequence at next frame boundary
- px_ready  in  1  source has a word
- px_trigger  out  1  consume word (source pops when px_ready && px_trigger)
- px_data  in  16  source word; bits [11:0] are the pixel
- img_fv  out  1  frame valid, registered
- img_lv  out  1  line valid, registered
- img_d  out  12  pixel, registered
- status_busy  out  1  high when not Idle
- status_frameDone  out  1  toggles once per completed frame
- status_underrunCount  out  16  saturating count of pixels sent without px_ready

Behaviour:
- Async reset: state=Idle; img_fv=img_lv=0, img_d=0, status_frameDone=0, status_underrunCount=0, all counters 0; outputs drop the same instant, including mid-line.
- Outputs registered from "next" values: img_fv<=nextFv, img_lv<=nextLv, img_d<=nextLv ? (px_ready ? px_data[11:0] : 0) : 0.
- px_trigger = nextLv (combinational). It is high exactly ImageWidth cycles per line, each one cycle before the matching img_lv cycle.
- Underrun: if nextLv && !px_ready, img_d=0 and status_underrunCount increments, saturating at 16'hFFFF. Line timing is never stretched.
- img_d=0 whenever img_lv=0.
- States:
  - Idle: fv=0. cmd_trigger latches frames-left=cmd_frameCount, sets continuous=(cmd_frameCount==0), clears underrun count and stopReq, goes Lead.
  - Lead: fv=1, lv=0 for FvLeadCycles, then Line.
  - Line: fv=1, lv=1 for ImageWidth cycles, x counter 0..ImageWidth-1. After the last pixel: HBlank if y<ImageHeight-1, else Trail.
  - HBlank: fv=1, lv=0 for HBlankCycles, y++, then Line.
  - Trail: fv=1, lv=0 for FvTrailCycles, then VBlank. status_frameDone toggles on the cycle img_fv falls. Frames-left decrements here unless continuous.
  - VBlank: fv=0 for VBlankCycles. Then Idle if stopReq or (!continuous && frames-left==0); else Lead.
- Latency: trigger at edge N → img_fv=1 after edge N+1.
- Frame length: img_fv high for FvLead + H*W + (H-1)*HBlank + FvTrail cycles.
- cmd_stop while busy sets stopReq; the frame in progress completes fully including VBlank. cmd_stop in Idle is ignored.
- cmd_trigger and cmd_stop in the same Idle cycle: trigger starts, stop ignored.
- cmd_trigger while busy: ignored.
- Counter widths use RegWidth of each parameter; no wrap beyond parameter limits.

Optional Feature:
- Macro IMG_SENSOR_TX_PATTERN_EN.
- Defined: adds input cmd_pattern (1 bit, sampled on cmd_trigger).
  - When set, pixel = (x + y*ImageWidth) mod 4096 from an internal counter that resets at each frame start.
  - px_trigger held 0; underruns never counted.
- Not defined: no cmd_pattern port; pixels always from px source.

Test Plan:
- Params W=4,H=3,Lead=2,HBlank=3,Trail=2,VBlank=5; cmd_frameCount=1, px always ready with data 0x0..0xB → img_fv high 22 cycles, 3 lv bursts of 4, img_d sequence 0..B, frameDone toggles once, busy falls after VBlank, underrunCount=0.
- Same params, px_ready low for pixel index 5 only → img_d at that slot = 0, underrunCount=1, lv timing unchanged, 11 words popped.
- cmd_frameCount=0, cmd_stop issued mid-frame 2 → frame 2 completes, 5-cycle VBlank, Idle; frameDone toggled exactly twice.
- rst asserted during second line → img_fv/img_lv/img_d 0 immediately; next cmd_trigger produces a full clean 22-cycle frame.
- cmd_trigger repeated while busy, cmd_frameCount=3 → ignored; exactly 3 frames, each separated by 5 fv-low cycles.
- With IMG_SENSOR_TX_PATTERN_EN, cmd_pattern=1 → img_d = 0,1,…,11 across frame, px_trigger never high, pattern restarts at 0 next frame.
